// File: rtl/encode_mul_pkg.sv
// Shared widths, sideband layout and output rounding/saturation for the encoder multiply pipe.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package encode_mul_pkg;

  // Defaults for the encoder datapath instance
  localparam int DIN0_WIDTH_DFLT = 40;
  localparam int DIN1_WIDTH_DFLT = 23;
  localparam int DOUT_WIDTH_DFLT = 62;
  localparam int ACC_GUARD_DFLT  = 8;
  localparam int SHIFT_W_DFLT    = 6;

  // Fixed-width container used by the rounding helper; must exceed ACC_W+1
  localparam int MAX_W = 128;
  // Width of the shift field carried in the sideband bundle; must be >= SHIFT_W
  localparam int SHIFT_MAX_W = 8;

  function automatic int calc_prod_w(input int din0_w, input int din1_w);
    return din0_w + din1_w;
  endfunction

  function automatic int calc_acc_w(input int din0_w, input int din1_w, input int guard);
    return din0_w + din1_w + guard;
  endfunction

  // Sideband travelling alongside the product
  typedef struct packed {
    logic                   vld;
    logic                   last;
    logic                   acc_en;
    logic [SHIFT_MAX_W-1:0] shift;
  } sideband_t;

  // Round-half-up arithmetic right shift followed by signed saturation to out_w bits.
  // value must already be sign-extended to MAX_W. Returns {sat, dout} with dout
  // sign-extended in the low MAX_W bits. Since value fits in well under MAX_W bits,
  // adding the rounding constant can never overflow the container.
  function automatic logic [MAX_W:0] rnd_shift_sat(input logic signed [MAX_W-1:0] value,
                                                   input int unsigned shift,
                                                   input int unsigned out_w);
    logic signed [MAX_W-1:0] half;
    logic signed [MAX_W-1:0] t;
    logic signed [MAX_W-1:0] hi;
    logic signed [MAX_W-1:0] lo;
    logic [MAX_W:0]          res;
    half = '0;
    if (shift != 0) half = MAX_W'(1) << (shift - 1);
    t  = (value + half) >>> shift;
    hi = (MAX_W'(1) << (out_w - 1)) - MAX_W'(1);
    lo = ~hi;
    if (t > hi)      res = {1'b1, hi};
    else if (t < lo) res = {1'b1, lo};
    else             res = {1'b0, t};
    return res;
  endfunction

endpackage

// File: rtl/encode_mul_pipe_core.sv
// Signed product pipeline: NUM_STAGE ce-gated registers carrying product and sideband together.
// Latency: NUM_STAGE ce=1 cycles from din0/din1/sb_in to prod/sb_out.
// Backpressure: none; ce=0 freezes every stage, nothing is dropped or duplicated.
//
// Ports: clk, reset (async active-low), ce; din0/din1 signed operands; sb_in sideband;
//        prod full-precision product and sb_out sideband at the last stage.
module encode_mul_pipe_core
  import encode_mul_pkg::*;
#(
  parameter int DIN0_WIDTH = DIN0_WIDTH_DFLT,
  parameter int DIN1_WIDTH = DIN1_WIDTH_DFLT,
  parameter int NUM_STAGE  = 2
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      ce,
  input  logic signed [DIN0_WIDTH-1:0]              din0,
  input  logic signed [DIN1_WIDTH-1:0]              din1,
  input  sideband_t                                 sb_in,
  output logic signed [DIN0_WIDTH+DIN1_WIDTH-1:0]   prod,
  output sideband_t                                 sb_out
);

  localparam int PROD_W = calc_prod_w(DIN0_WIDTH, DIN1_WIDTH);

  logic signed [PROD_W-1:0] prod_q [NUM_STAGE];
  sideband_t                sb_q   [NUM_STAGE];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_STAGE; i++) begin
        prod_q[i] <= '0;
        sb_q[i]   <= '0;
      end
    end else if (ce) begin
      // Operands sign-extended to the product width so the multiply is full precision
      prod_q[0] <= PROD_W'(din0) * PROD_W'(din1);
      sb_q[0]   <= sb_in;
      for (int i = 1; i < NUM_STAGE; i++) begin
        prod_q[i] <= prod_q[i-1];
        sb_q[i]   <= sb_q[i-1];
      end
    end
  end

  assign prod   = prod_q[NUM_STAGE-1];
  assign sb_out = sb_q[NUM_STAGE-1];

endmodule

// File: rtl/encode_mul_acc_pipe.sv
// Signed multiply / grouped multiply-accumulate with round-half-up shift and output saturation.
// Latency: NUM_STAGE+1 ce=1 cycles from input beat to dout.
// Backpressure: none; ce=0 freezes the whole pipe and holds dout/dout_vld/sat.
//
// Ports: clk, reset (async active-low), ce; din_vld/din_last/acc_en/shift beat controls;
//        din0/din1 signed operands; dout_vld/dout/sat registered result.
module encode_mul_acc_pipe
  import encode_mul_pkg::*;
#(
  parameter int DIN0_WIDTH = DIN0_WIDTH_DFLT,
  parameter int DIN1_WIDTH = DIN1_WIDTH_DFLT,
  parameter int DOUT_WIDTH = DOUT_WIDTH_DFLT,
  parameter int NUM_STAGE  = 2,
  parameter int ACC_GUARD  = ACC_GUARD_DFLT,
  parameter int SHIFT_W    = SHIFT_W_DFLT
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ce,
  input  logic                         din_vld,
  input  logic                         din_last,
  input  logic                         acc_en,
  input  logic [SHIFT_W-1:0]           shift,
  input  logic signed [DIN0_WIDTH-1:0] din0,
  input  logic signed [DIN1_WIDTH-1:0] din1,
  output logic                         dout_vld,
  output logic signed [DOUT_WIDTH-1:0] dout,
  output logic                         sat
);

  localparam int PROD_W = calc_prod_w(DIN0_WIDTH, DIN1_WIDTH);
  localparam int ACC_W  = calc_acc_w(DIN0_WIDTH, DIN1_WIDTH, ACC_GUARD);

  sideband_t                sb_in;
  sideband_t                sb_out;
  logic signed [PROD_W-1:0] prod;

  always_comb begin
    sb_in        = '0;
    sb_in.vld    = din_vld;
    sb_in.last   = din_last;
    sb_in.acc_en = acc_en;
    sb_in.shift  = SHIFT_MAX_W'(shift);
  end

  encode_mul_pipe_core #(
    .DIN0_WIDTH (DIN0_WIDTH),
    .DIN1_WIDTH (DIN1_WIDTH),
    .NUM_STAGE  (NUM_STAGE)
  ) u_core (
    .clk    (clk),
    .reset  (reset),
    .ce     (ce),
    .din0   (din0),
    .din1   (din1),
    .sb_in  (sb_in),
    .prod   (prod),
    .sb_out (sb_out)
  );

  // Accumulator state; acc wraps modulo 2^ACC_W
  logic signed [ACC_W-1:0] acc_q;
  logic                    open_q;

  logic signed [ACC_W-1:0]  prod_x;
  logic signed [ACC_W-1:0]  sum;
  logic signed [ACC_W-1:0]  res;
  logic signed [ACC_W-1:0]  acc_d;
  logic                     open_d;
  logic                     emit;
  logic [MAX_W:0]           rs;
  logic signed [DOUT_WIDTH-1:0] dout_d;
  logic                     sat_d;
  logic                     unused_rs;

  always_comb begin
    prod_x = ACC_W'(prod);
    // An acc_en beat with no open group starts from zero, so stale acc never leaks in
    sum    = (open_q ? acc_q : '0) + prod_x;
    res    = sb_out.acc_en ? sum : prod_x;
    emit   = sb_out.vld & (~sb_out.acc_en | sb_out.last);

    acc_d  = acc_q;
    open_d = open_q;
    if (sb_out.vld) begin
      if (sb_out.acc_en && !sb_out.last) begin
        acc_d  = sum;
        open_d = 1'b1;
      end else begin
        // Group closed, or a plain beat aborting any open group
        acc_d  = '0;
        open_d = 1'b0;
      end
    end

    // Shifting out every magnitude bit leaves only the sign; rounding is not applied there
    if (32'(sb_out.shift) >= 32'(ACC_W)) begin
      rs = {1'b0, {MAX_W{res[ACC_W-1]}}};
    end else begin
      rs = rnd_shift_sat(MAX_W'(res), 32'(sb_out.shift), 32'(DOUT_WIDTH));
    end
    sat_d     = rs[MAX_W];
    dout_d    = rs[DOUT_WIDTH-1:0];
    unused_rs = ^rs[MAX_W-1:DOUT_WIDTH];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q    <= '0;
      open_q   <= 1'b0;
      dout_vld <= 1'b0;
      dout     <= '0;
      sat      <= 1'b0;
    end else if (ce) begin
      acc_q    <= acc_d;
      open_q   <= open_d;
      dout_vld <= emit;
      // dout/sat keep the last emitted result across non-emitting beats
      if (emit) begin
        dout <= dout_d;
        sat  <= sat_d;
      end
    end
  end

endmodule

// File: tb/tb_encode_mul_acc_pipe.sv
module tb_encode_mul_acc_pipe;

  localparam int LAT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset;
  logic               ce;
  logic               din_vld;
  logic               din_last;
  logic               acc_en;
  logic [5:0]         shift;
  logic signed [39:0] din0;
  logic signed [22:0] din1;
  logic               dout_vld;
  logic signed [61:0] dout;
  logic               sat;

  encode_mul_acc_pipe #(
    .DIN0_WIDTH (40),
    .DIN1_WIDTH (23),
    .DOUT_WIDTH (62),
    .NUM_STAGE  (2),
    .ACC_GUARD  (8),
    .SHIFT_W    (6)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ce       (ce),
    .din_vld  (din_vld),
    .din_last (din_last),
    .acc_en   (acc_en),
    .shift    (shift),
    .din0     (din0),
    .din1     (din1),
    .dout_vld (dout_vld),
    .dout     (dout),
    .sat      (sat)
  );

  // Reference model: beats in flight, then group arithmetic on integers
  typedef struct {
    bit     vld;
    bit     last;
    bit     acc;
    int     sh;
    longint a;
    longint b;
  } beat_t;

  beat_t              pipe_q[$];
  logic signed [70:0] m_acc;
  bit                 m_open;
  logic signed [61:0] m_dout;
  bit                 m_sat;
  bit                 m_vld;
  longint             got_q[$];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    pipe_q.delete();
    m_acc  = '0;
    m_open = 0;
    m_dout = '0;
    m_sat  = 0;
    m_vld  = 0;
  endfunction

  function automatic void model_emit(input logic signed [70:0] r, input int sh);
    logic signed [127:0] w;
    logic signed [127:0] t;
    logic signed [127:0] lim;
    w = r;
    if (sh > 0) w = w + (128'sd1 <<< (sh - 1));
    t   = w >>> sh;
    lim = 128'sd1 <<< 61;
    if (t >= lim) begin
      m_dout = 62'(lim - 128'sd1);
      m_sat  = 1;
    end else if (t < -lim) begin
      m_dout = 62'(-lim);
      m_sat  = 1;
    end else begin
      m_dout = 62'(t);
      m_sat  = 0;
    end
    m_vld = 1;
  endfunction

  function automatic void model_step(input beat_t nb);
    beat_t              x;
    logic signed [70:0] p;
    logic signed [70:0] s;
    pipe_q.push_back(nb);
    m_vld = 0;
    if (pipe_q.size() == LAT) begin
      x = pipe_q.pop_front();
      if (x.vld) begin
        p = 71'(x.a * x.b);
        if (!x.acc) begin
          model_emit(p, x.sh);
          m_acc  = '0;
          m_open = 0;
        end else begin
          s = (m_open ? m_acc : 71'sd0) + p;
          if (x.last) begin
            model_emit(s, x.sh);
            m_acc  = '0;
            m_open = 0;
          end else begin
            m_acc  = s;
            m_open = 1;
          end
        end
      end
    end
  endfunction

  // One clock: drive a beat, advance model on ce=1, check outputs #1 after the edge
  task automatic cyc(input int c, input int v, input int l, input int ac, input int sh,
                     input longint a, input longint b);
    beat_t nb;
    ce       = (c != 0);
    din_vld  = (v != 0);
    din_last = (l != 0);
    acc_en   = (ac != 0);
    shift    = 6'(sh);
    din0     = a[39:0];
    din1     = b[22:0];
    nb.vld = (v != 0); nb.last = (l != 0); nb.acc = (ac != 0); nb.sh = sh;
    nb.a = longint'(din0); nb.b = longint'(din1);
    @(posedge clk);
    if (c != 0) model_step(nb);
    #1;
    chk("vld",  dout_vld, m_vld);
    chk("dout", dout,     m_dout);
    chk("sat",  sat,      m_sat);
    if (c != 0 && dout_vld) got_q.push_back(longint'(dout));
  endtask

  task automatic flush(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic expect_got(input string tag, input int idx, input longint v);
    longint obs;
    obs = (idx < got_q.size()) ? got_q[idx] : 64'sh7EAD_0000_0000_0000;
    chk(tag, obs, v);
  endtask

  initial begin
    reset = 1'b0; ce = 1'b0; din_vld = 1'b0; din_last = 1'b0; acc_en = 1'b0;
    shift = '0; din0 = '0; din1 = '0;
    model_reset();
    #3;
    chk("rst_dout", dout, 0);
    chk("rst_vld",  dout_vld, 0);
    chk("rst_sat",  sat, 0);
    @(posedge clk);
    #3 reset = 1'b1;

    // Plain multiply, back to back
    got_q.delete();
    cyc(1, 1, 0, 0, 0, -3, 5);
    cyc(1, 1, 0, 0, 0, 1000, -7);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("mul_first_vld", dout_vld, 1);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("mul_second_vld", dout_vld, 1);
    flush(2);
    chk("mul_n", got_q.size(), 2);
    expect_got("mul0", 0, -15);
    expect_got("mul1", 1, -7000);

    // Accumulation group, then a single-beat group
    got_q.delete();
    cyc(1, 1, 0, 1, 0, 2, 3);
    cyc(1, 1, 0, 1, 0, 4, 5);
    cyc(1, 1, 0, 1, 0, -1, 6);
    cyc(1, 1, 1, 1, 0, 7, 1);
    cyc(1, 1, 1, 1, 0, 1, 1);
    flush(3);
    chk("acc_n", got_q.size(), 2);
    expect_got("acc_sum", 0, 27);
    expect_got("acc_single", 1, 1);

    // ce stall with two beats in flight; inputs during the stall must be ignored
    got_q.delete();
    cyc(1, 1, 0, 0, 0, 11, 3);
    cyc(1, 1, 0, 0, 0, -4, 6);
    for (int i = 0; i < 5; i++) cyc(0, 1, 1, 0, 0, 99, 99);
    chk("stall_vld_frozen", dout_vld, 0);
    flush(3);
    chk("stall_n", got_q.size(), 2);
    expect_got("stall0", 0, 33);
    expect_got("stall1", 1, -24);

    // Rounding and saturation
    got_q.delete();
    cyc(1, 1, 0, 0, 1, 7, 1);
    cyc(1, 1, 0, 0, 1, -7, 1);
    cyc(1, 1, 0, 1, 0, 64'h7F_FFFF_FFFF, 64'h3F_FFFF);
    cyc(1, 1, 1, 1, 0, 64'h7F_FFFF_FFFF, 64'h3F_FFFF);
    flush(3);
    chk("rs_n", got_q.size(), 3);
    expect_got("round_pos", 0, 4);
    expect_got("round_neg", 1, -3);
    expect_got("sat_max", 2, 64'sh1FFF_FFFF_FFFF_FFFF);
    chk("sat_flag", sat, 1);

    // Abort an open group with a plain beat
    got_q.delete();
    cyc(1, 1, 0, 1, 0, 5, 5);
    cyc(1, 1, 0, 1, 0, 5, 5);
    cyc(1, 1, 0, 0, 0, 2, 2);
    cyc(1, 1, 1, 1, 0, 1, 3);
    flush(3);
    chk("abort_n", got_q.size(), 2);
    expect_got("abort_plain", 0, 4);
    expect_got("abort_next", 1, 3);

    // Reset in the middle of an open group with beats in flight
    cyc(1, 1, 0, 1, 0, 9, 9);
    cyc(1, 1, 0, 1, 0, 9, 9);
    cyc(1, 1, 0, 0, 0, 4, 4);
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_dout", dout, 0);
    chk("mid_rst_vld",  dout_vld, 0);
    chk("mid_rst_sat",  sat, 0);
    model_reset();
    @(posedge clk);
    #3 reset = 1'b1;
    got_q.delete();
    cyc(1, 1, 0, 0, 0, -3, 5);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("lat_c2_vld", dout_vld, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("lat_c3_vld", dout_vld, 1);
    chk("lat_c3_dout", dout, -15);
    cyc(1, 1, 1, 1, 0, 1, 1);
    flush(3);
    expect_got("post_rst_group", 1, 1);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      int     c, v, l, ac, sh;
      longint a, b;
      c  = ($urandom_range(0, 9) != 0) ? 1 : 0;
      v  = ($urandom_range(0, 3) != 0) ? 1 : 0;
      ac = ($urandom_range(0, 2) != 0) ? 1 : 0;
      l  = ($urandom_range(0, 2) == 0) ? 1 : 0;
      sh = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 63)) : 0;
      a  = longint'({$urandom(), $urandom()});
      b  = longint'({$urandom(), $urandom()});
      if ($urandom_range(0, 1) == 0) begin
        a = longint'($signed(8'($urandom())));
        b = longint'($signed(8'($urandom())));
      end
      cyc(c, v, l, ac, sh, a, b);
    end
    flush(3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
